ram_arbiter: RTL and testbench

- Multi-core front end for the single-ported RAM. Shares the RAM between CPUS cores, each with one I-port and one D-port.
- Selects one requester per transaction and holds that grant until the RAM reports ACCESS. Then releases that requester's wait and advances a round-robin pointer.
- Sits between the per-core cache/datapath request ports and the ram ramaddr/ramREN/ramWEN/ramstate interface. Replaces the stateless single-core D-over-I mux.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/rr_picker.sv | 35 +++
 rtl/ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types for the memory front end.
// Includes arbiter state and request kinds.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef enum logic [1:0] {
    DWR,
    DRD,
    IRD
  } req_kind_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select over per-core pending bits.
// Rotates by ptr, then priority-encodes the lowest set bit.
module rr_picker #(
  parameter int CPUS = 2,
  parameter int PW   = 1
) (
  input  logic [CPUS-1:0] pend,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  localparam logic [PW:0] NC = (PW+1)'(CPUS);

  logic [CPUS-1:0] rot;
  logic [PW:0]     sum;

  always_comb begin
    rot   = CPUS'({pend, pend} >> ptr);
    valid = |pend;
    win   = '0;
    sum   = '0;
    // Descending scan so the lowest rotated index wins.
    for (int i = CPUS-1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (PW+1)'(i);
        if (sum >= NC) begin
          sum = sum - NC;
        end
        win = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among CPUS cores,
// each with an I-port and a D-port.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  ramstate_t                ramstate,
  input  logic [WORD_W-1:0]        ramload
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CPUS-1);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     g_cpu_q, g_cpu_d;
  req_kind_t         g_kind_q, g_kind_d;
  logic [WORD_W-1:0] g_addr_q, g_addr_d;
  logic [WORD_W-1:0] g_data_q, g_data_d;

  logic [CPUS-1:0]   pend;
  logic [PW-1:0]     win;
  logic              win_vld;
  logic              req_live;
  logic              done;

  assign pend = iREN | dREN | dWEN;

  rr_picker #(
    .CPUS (CPUS),
    .PW   (PW)
  ) u_pick (
    .pend  (pend),
    .ptr   (rr_ptr_q),
    .win   (win),
    .valid (win_vld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      g_cpu_q  <= '0;
      g_kind_q <= DWR;
      g_addr_q <= '0;
      g_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_cpu_q  <= g_cpu_d;
      g_kind_q <= g_kind_d;
      g_addr_q <= g_addr_d;
      g_data_q <= g_data_d;
    end
  end

  // Granted request still held by its requester.
  always_comb begin
    req_live = 1'b0;
    unique case (g_kind_q)
      DWR:     req_live = dWEN[g_cpu_q];
      DRD:     req_live = dREN[g_cpu_q];
      IRD:     req_live = iREN[g_cpu_q];
      default: req_live = 1'b0;
    endcase
  end

  assign done = (state_q == GRANT) && req_live
             && (ramstate == ACCESS);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_cpu_d  = g_cpu_q;
    g_kind_d = g_kind_q;
    g_addr_d = g_addr_q;
    g_data_d = g_data_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = GRANT;
          g_cpu_d  = win;
          g_addr_d = daddr[int'(win)*WORD_W +: WORD_W];
          g_data_d = dstore[int'(win)*WORD_W +: WORD_W];
          if (dWEN[win]) begin
            g_kind_d = DWR;
          end else if (dREN[win]) begin
            g_kind_d = DRD;
          end else begin
            g_kind_d = IRD;
            g_addr_d = iaddr[int'(win)*WORD_W +: WORD_W];
            g_data_d = '0;
          end
        end
      end
      GRANT: begin
        if (!req_live) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          state_d  = IDLE;
          rr_ptr_d = (g_cpu_q == LAST) ? '0
                   : g_cpu_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = (state_q == GRANT) && (g_kind_q != DWR);
    ramWEN   = (state_q == GRANT) && (g_kind_q == DWR);
    ramaddr  = g_addr_q;
    ramstore = g_data_q;
    if (done) begin
      unique case (g_kind_q)
        IRD: begin
          iwait[g_cpu_q] = 1'b0;
          iload[int'(g_cpu_q)*WORD_W +: WORD_W] = ramload;
        end
        DRD: begin
          dwait[g_cpu_q] = 1'b0;
          dload[int'(g_cpu_q)*WORD_W +: WORD_W] = ramload;
        end
        DWR: dwait[g_cpu_q] = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a transaction-level model
// checked every cycle plus hand-computed literal checks.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic [CPUS-1:0]      iREN, dREN, dWEN;
  logic [CPUS*W-1:0]    iaddr, daddr, dstore;
  logic [CPUS-1:0]      iwait, dwait;
  logic [CPUS*W-1:0]    iload, dload;
  logic [W-1:0]         ramaddr, ramstore, ramload;
  logic                 ramREN, ramWEN;
  ramstate_t            ramstate;

  always #5 CLK = ~CLK;

  ram_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstate(ramstate), .ramload(ramload)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: kind 0=write, 1=data read, 2=instr read.
  bit          m_busy;
  int          m_cpu, m_kind, m_ptr;
  logic [W-1:0] m_addr, m_data;
  int          glog[$];
  int          sel;

  function automatic logic req_bit(int c, int k);
    if (k == 0) return dWEN[c];
    if (k == 1) return dREN[c];
    return iREN[c];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_cpu  <= 0;
      m_kind <= 0;
    end else if (!m_busy) begin
      sel = -1;
      for (int k = 0; k < CPUS; k++) begin
        if (sel < 0 && (iREN[(m_ptr+k)%CPUS] |
            dREN[(m_ptr+k)%CPUS] | dWEN[(m_ptr+k)%CPUS]))
          sel = (m_ptr + k) % CPUS;
      end
      if (sel >= 0) begin
        m_busy <= 1'b1;
        m_cpu  <= sel;
        glog.push_back(sel);
        if (dWEN[sel]) begin
          m_kind <= 0;
          m_addr <= daddr[sel*W +: W];
          m_data <= dstore[sel*W +: W];
        end else if (dREN[sel]) begin
          m_kind <= 1;
          m_addr <= daddr[sel*W +: W];
        end else begin
          m_kind <= 2;
          m_addr <= iaddr[sel*W +: W];
        end
      end
    end else if (!req_bit(m_cpu, m_kind)) begin
      m_busy <= 1'b0;
    end else if (ramstate == ACCESS) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_cpu + 1) % CPUS;
    end
  end

  logic [CPUS-1:0]   e_iw, e_dw;
  logic [CPUS*W-1:0] e_il, e_dl;
  logic              e_done;

  always @(negedge CLK) begin
    if (nRST) begin
      e_done = m_busy && req_bit(m_cpu, m_kind)
            && (ramstate == ACCESS);
      e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
      if (e_done) begin
        if (m_kind == 2) begin
          e_iw[m_cpu] = 1'b0;
          e_il[m_cpu*W +: W] = ramload;
        end else begin
          e_dw[m_cpu] = 1'b0;
          if (m_kind == 1) e_dl[m_cpu*W +: W] = ramload;
        end
      end
      chk("m_ren", 64'(ramREN), 64'(m_busy && m_kind != 0));
      chk("m_wen", 64'(ramWEN), 64'(m_busy && m_kind == 0));
      chk("m_iwait", 64'(iwait), 64'(e_iw));
      chk("m_dwait", 64'(dwait), 64'(e_dw));
      chk("m_iload", 64'(iload), 64'(e_il));
      chk("m_dload", 64'(dload), 64'(e_dl));
      if (m_busy) chk("m_addr", 64'(ramaddr), 64'(m_addr));
      if (m_busy && m_kind == 0)
        chk("m_store", 64'(ramstore), 64'(m_data));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [1:0] rr_pat [8];

  initial begin
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    rr_pat = '{2'b11, 2'b10, 2'b11, 2'b01,
               2'b11, 2'b10, 2'b11, 2'b01};

    #12;
    chk("rst_ren", 64'(ramREN), 64'd0);
    chk("rst_wen", 64'(ramWEN), 64'd0);
    chk("rst_iwait", 64'(iwait), 64'h3);
    chk("rst_dwait", 64'(dwait), 64'h3);
    chk("rst_iload", 64'(iload), 64'd0);
    chk("rst_addr", 64'(ramaddr), 64'd0);
    chk("rst_store", 64'(ramstore), 64'd0);
    #5 nRST = 1'b1;

    // single read, ACCESS on third GRANT cycle
    tick; iaddr[31:0] = 32'h40; iREN = 2'b01; ramstate = BUSY;
    #2 chk("rd_idle", 64'(ramREN), 64'd0);
    tick; #2 chk("rd_ren1", 64'(ramREN), 64'd1);
    chk("rd_addr", 64'(ramaddr), 64'h40);
    chk("rd_wait1", 64'(iwait), 64'h3);
    tick; #2 chk("rd_ren2", 64'(ramREN), 64'd1);
    chk("rd_wait2", 64'(iwait), 64'h3);
    tick; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #2 chk("rd_ren3", 64'(ramREN), 64'd1);
    chk("rd_pulse", 64'(iwait), 64'h2);
    chk("rd_load", 64'(iload), 64'h00000000_DEADBEEF);
    tick; iREN = '0; ramstate = FREE;
    #2 chk("rd_after", 64'(iwait), 64'h3);
    chk("rd_ren4", 64'(ramREN), 64'd0);
    chk("rd_ptr", 64'(m_ptr), 64'd1);

    // core1 write beats its own I read
    tick; dWEN = 2'b10; daddr[63:32] = 32'h80;
    dstore[63:32] = 32'h1234; iREN = 2'b10;
    iaddr[63:32] = 32'h100; ramstate = ACCESS;
    ramload = 32'hCAFE0001;
    #2 chk("pr_idle", 64'(ramWEN | ramREN), 64'd0);
    tick; #2 chk("pr_wen", 64'(ramWEN), 64'd1);
    chk("pr_store", 64'(ramstore), 64'h1234);
    chk("pr_addr", 64'(ramaddr), 64'h80);
    chk("pr_dwait", 64'(dwait), 64'h1);
    tick; dWEN = '0;
    #2 chk("pr_idle2", 64'(ramWEN | ramREN), 64'd0);
    tick; #2 chk("pr_ren", 64'(ramREN), 64'd1);
    chk("pr_iaddr", 64'(ramaddr), 64'h100);
    chk("pr_iwait", 64'(iwait), 64'h1);
    chk("pr_iload", 64'(iload), 64'hCAFE0001_00000000);
    tick; iREN = '0;
    #2 chk("pr_ptr", 64'(m_ptr), 64'd0);

    // round robin, both cores reading continuously
    tick; dREN = 2'b11; daddr[31:0] = 32'h200;
    daddr[63:32] = 32'h300; ramload = 32'h5555AAAA;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      #2 chk("rr_dwait", 64'(dwait), 64'(rr_pat[k]));
      if (k % 4 == 1) chk("rr_a0", 64'(ramaddr), 64'h200);
      if (k % 4 == 3) chk("rr_a1", 64'(ramaddr), 64'h300);
    end
    tick; dREN = '0;
    #2 chk("rr_end", 64'(dwait), 64'h3);
    chk("rr_log", 64'({glog[3], glog[4], glog[5], glog[6]}),
        64'({32'd0, 32'd1, 32'd0, 32'd1}));

    // abort: core0 drops while BUSY, core1 goes next
    tick; dREN = 2'b11; ramstate = BUSY;
    #2 chk("ab_idle", 64'(ramREN), 64'd0);
    tick; #2 chk("ab_ren", 64'(ramREN), 64'd1);
    chk("ab_addr0", 64'(ramaddr), 64'h200);
    tick; dREN = 2'b10;
    #2 chk("ab_drop", 64'(dwait), 64'h3);
    tick; #2 chk("ab_idle2", 64'(ramREN), 64'd0);
    chk("ab_ptr", 64'(m_ptr), 64'd0);
    tick; #2 chk("ab_addr1", 64'(ramaddr), 64'h300);
    tick; ramstate = ACCESS;
    #2 chk("ab_pulse", 64'(dwait), 64'h1);
    tick; dREN = '0; ramstate = FREE;
    #2 chk("ab_end", 64'(dwait), 64'h3);
    chk("ab_log", 64'({glog[7], glog[8]}),
        64'({32'd0, 32'd1}));

    // ERROR is retried silently
    tick; iREN = 2'b01; iaddr[31:0] = 32'h44; ramstate = ERROR;
    #2 chk("er_idle", 64'(ramREN), 64'd0);
    tick; #2 chk("er_ren1", 64'(ramREN), 64'd1);
    chk("er_wait1", 64'(iwait), 64'h3);
    chk("er_addr", 64'(ramaddr), 64'h44);
    tick; #2 chk("er_ren2", 64'(ramREN), 64'd1);
    chk("er_wait2", 64'(iwait), 64'h3);
    tick; ramstate = ACCESS; ramload = 32'h0BADF00D;
    #2 chk("er_pulse", 64'(iwait), 64'h2);
    chk("er_load", 64'(iload), 64'h00000000_0BADF00D);
    tick; iREN = '0; ramstate = FREE;
    #2 chk("er_end", 64'(iwait), 64'h3);

    // reset in the middle of a core1 grant
    tick; iREN = 2'b10; iaddr[63:32] = 32'h88; ramstate = BUSY;
    tick; #2 chk("mr_ren", 64'(ramREN), 64'd1);
    chk("mr_addr", 64'(ramaddr), 64'h88);
    nRST = 1'b0;
    #1 chk("mr_ren0", 64'(ramREN), 64'd0);
    chk("mr_iwait", 64'(iwait), 64'h3);
    chk("mr_dwait", 64'(dwait), 64'h3);
    tick; nRST = 1'b1; iREN = 2'b11; iaddr[31:0] = 32'h10;
    ramstate = ACCESS; ramload = 32'h77;
    #2 chk("mr_idle", 64'(ramREN), 64'd0);
    tick; #2 chk("mr_first", 64'(iwait), 64'h2);
    chk("mr_a0", 64'(ramaddr), 64'h10);
    tick; iREN = '0; ramstate = FREE;
    #2 chk("mr_end", 64'(iwait), 64'h3);

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
